// File: rtl/axi_lite_read_arbiter.sv
// 2:1 round-robin AXI4-Lite read arbiter sharing one memory read port
// between instruction fetch (m0) and data load (m1); one read in flight.
module axi_lite_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [2:0]            m0_arprot,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [2:0]            m1_arprot,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arprot,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  rd_grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  win;
  logic                  rdy;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arprot_d   = arprot_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = '0;
    m1_rresp   = '0;
    rdy        = 1'b0;
    // On a tie the requester that did not win last time goes first
    win = (m0_arvalid & m1_arvalid) ? ~last_q : m1_arvalid;
    unique case (state_q)
      IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          m0_arready = ~win;
          m1_arready = win;
          grant_d    = win;
          araddr_d   = win ? m1_araddr : m0_araddr;
          arprot_d   = win ? m1_arprot : m0_arprot;
          arvalid_d  = 1'b1;
          state_d    = AR;
        end
      end
      AR: begin
        if (s_arready) begin
          arvalid_d = 1'b0;
          state_d   = R;
        end
      end
      R: begin
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          rdy       = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          rdy       = m0_rready;
        end
        if (s_rvalid & rdy) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (areset) begin
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      rdy        = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b1;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arprot_q  <= arprot_d;
    end
  end

  assign s_arvalid = arvalid_q;
  assign s_araddr  = araddr_q;
  assign s_arprot  = arprot_q;
  assign s_rready  = rdy;
  assign rd_grant  = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Random-traffic bench for axi_lite_read_arbiter against a
// transaction-level model of requesters, arbitration and memory.
module tb_axi_lite_read_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [2:0]  m0_arprot;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [2:0]  m1_arprot;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [2:0]  s_arprot;
  logic [1:0]  s_rresp;
  logic        rd_grant, busy;

  axi_lite_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .rd_grant(rd_grant), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_d(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] mem_r(input logic [31:0] a);
    return a[5:4];
  endfunction

  // requester queues: one pending address each, held until accepted
  bit          pend [2];
  logic [31:0] paddr [2];
  logic [2:0]  pprot [2];
  bit          rrdy [2];
  // one transaction in flight
  bit          out_v, ar_done, own, last, g_exp;
  logic [31:0] cur_addr, exp_saddr;
  logic [2:0]  exp_sprot;
  bit          srv_hold;
  bit          rst_now, acc, hs_ar, hs_r, w, any_req, dp;
  int          served [2];
  logic        rv_i, ar_i;
  logic [31:0] rd_i;
  logic [1:0]  rr_i;

  task automatic model_reset();
    out_v     = 1'b0;
    ar_done   = 1'b0;
    last      = 1'b1;
    g_exp     = 1'b1;
    exp_saddr = '0;
    exp_sprot = '0;
    srv_hold  = 1'b0;
  endtask

  initial begin
    areset     = 1'b1;
    m0_arvalid = 0; m0_araddr = 0; m0_arprot = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arprot = 0; m1_rready = 0;
    s_arready  = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; paddr[i] = 0; pprot[i] = 0; rrdy[i] = 0;
      served[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge aclk);
      rst_now = areset;
      acc = 0; hs_ar = 0; hs_r = 0; w = 0;
      if (!rst_now) begin
        chk("busy", busy, out_v);
        chk("s_arvalid", s_arvalid, out_v && !ar_done);
        chk("s_araddr", s_araddr, exp_saddr);
        chk("s_arprot", s_arprot, exp_sprot);
        chk("rd_grant", rd_grant, g_exp);
        any_req = pend[0] | pend[1];
        w = (pend[0] && pend[1]) ? !last : pend[1];
        chk("m0_arready", m0_arready, !out_v && any_req && !w);
        chk("m1_arready", m1_arready, !out_v && any_req && w);
        dp = out_v && ar_done;
        for (int i = 0; i < 2; i++) begin
          rv_i = i ? m1_rvalid : m0_rvalid;
          rd_i = i ? m1_rdata : m0_rdata;
          rr_i = i ? m1_rresp : m0_rresp;
          if (dp && own == i[0]) begin
            chk($sformatf("m%0d_rvalid", i), rv_i, s_rvalid);
            chk("s_rready", s_rready, rrdy[i]);
            if (s_rvalid) begin
              chk($sformatf("m%0d_rdata", i), rd_i, mem_d(cur_addr));
              chk($sformatf("m%0d_rresp", i), rr_i, mem_r(cur_addr));
            end
          end else begin
            chk($sformatf("m%0d_rvalid_idle", i), rv_i, 1'b0);
            chk($sformatf("m%0d_rdata_idle", i), rd_i, 32'h0);
            chk($sformatf("m%0d_rresp_idle", i), rr_i, 2'b00);
          end
        end
        if (!dp) chk("s_rready_idle", s_rready, 1'b0);
        acc   = !out_v && any_req;
        hs_ar = out_v && !ar_done && s_arready;
        hs_r  = dp && s_rvalid && rrdy[own];
      end

      @(posedge aclk);
      #1;
      if (rst_now) begin
        model_reset();
      end else begin
        if (hs_r) begin
          out_v    = 1'b0;
          last     = own;
          srv_hold = 1'b0;
          served[own]++;
        end
        if (hs_ar) ar_done = 1'b1;
        if (acc) begin
          out_v     = 1'b1;
          ar_done   = 1'b0;
          own       = w;
          g_exp     = w;
          cur_addr  = paddr[w];
          exp_saddr = paddr[w];
          exp_sprot = pprot[w];
          pend[w]   = 1'b0;
        end
      end

      // occasional reset in the middle of a read
      areset = (cyc > 300) && out_v && ar_done && ($urandom_range(0, 40) == 0);

      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (cyc < 1200 || $urandom_range(0, 3) == 0) begin
            pend[i]  = 1'b1;
            paddr[i] = $urandom() & 32'hFFFF_FFFC;
            pprot[i] = 3'($urandom());
          end
        end
        rrdy[i] = ($urandom_range(0, 3) != 0);
      end
      m0_arvalid = pend[0];
      m0_araddr  = pend[0] ? paddr[0] : $urandom();
      m0_arprot  = pend[0] ? pprot[0] : 3'($urandom());
      m0_rready  = rrdy[0];
      m1_arvalid = pend[1];
      m1_araddr  = pend[1] ? paddr[1] : $urandom();
      m1_arprot  = pend[1] ? pprot[1] : 3'($urandom());
      m1_rready  = rrdy[1];

      // memory side: stray handshakes outside their phase must be ignored
      s_arready = 1'($urandom());
      if (out_v && ar_done) begin
        if (!srv_hold) srv_hold = ($urandom_range(0, 2) == 0);
        s_rvalid = srv_hold;
      end else begin
        s_rvalid = 1'($urandom());
      end
      if (out_v && ar_done && srv_hold) begin
        s_rdata = mem_d(cur_addr);
        s_rresp = mem_r(cur_addr);
      end else begin
        s_rdata = $urandom();
        s_rresp = 2'($urandom());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_arbiter.md
Name: axi_lite_read_arbiter

Overview:
- 2:1 AXI4-Lite read-channel arbiter that shares one memory read port between the instruction-fetch requester (m0) and the data-load requester (m1).
- Sits between the core's fetch and LSU read masters and the memory slave (s).
- At most one read is outstanding at a time. Round-robin arbitration. The write channels do not pass through this block.

Parameters:
- ADDR_WIDTH, 32, address width of all AR channels.
- DATA_WIDTH, 32, data width of all R channels.

Ports:
- aclk  in  1  clock
- areset  in  1  reset
- mN_arvalid  in  1  read-address valid from requester N (N=0 fetch, N=1 data)
- mN_arready  out  1  address accepted from requester N
- mN_araddr  in  ADDR_WIDTH  read address from requester N
- mN_arprot  in  3  protection bits from requester N
- mN_rvalid  out  1  read data valid to requester N
- mN_rready  in  1  requester N ready for read data
- mN_rdata  out  DATA_WIDTH  read data to requester N
- mN_rresp  out  2  read response to requester N
- s_arvalid  out  1  address valid to memory
- s_arready  in  1  memory accepted address
- s_araddr  out  ADDR_WIDTH  registered address to memory
- s_arprot  out  3  registered protection bits to memory
- s_rvalid  in  1  memory data valid
- s_rready  out  1  ready to memory
- s_rdata  in  DATA_WIDTH  memory data
- s_rresp  in  2  memory response
- rd_grant  out  1  current/last owner (0=m0, 1=m1)
- busy  out  1  state != IDLE

Behaviour:
- Reset: areset, synchronous, active-high; clock aclk.
- Reset values:
  - state=IDLE; last_grant=1, so m0 wins the first tie.
  - s_arvalid=0, s_araddr=0, s_arprot=0.
  - rd_grant=1, busy=0.
  - All mN_arready=0, mN_rvalid=0, s_rready=0.
- FSM IDLE:
  - If any mN_arvalid, select the winner.
  - Only one requester valid: it wins.
  - Both valid: the requester != last_grant wins.
  - Assert the winner's mN_arready combinationally in this cycle; the loser's arready=0.
  - Register its araddr/arprot into s_araddr/s_arprot, set rd_grant=winner, go to AR.
  - No request: stay in IDLE, all arready=0.
- FSM AR:
  - s_arvalid=1; s_araddr/s_arprot held stable.
  - On s_arready: go to R.
  - No requester arready is asserted in AR.
- FSM R:
  - Forward combinationally to the granted requester only: m[g]_rvalid=s_rvalid, m[g]_rdata=s_rdata, m[g]_rresp=s_rresp, s_rready=m[g]_rready.
  - Non-granted requester: rvalid=0, rdata=0, rresp=0.
  - On s_rvalid & m[g]_rready: last_grant<=g, go to IDLE.
- Latency:
  - Minimum 3 cycles per transaction (IDLE accept, AR, R), plus slave latency.
  - The next grant can occur in the IDLE cycle immediately after R completes.
- Stability:
  - A request arriving in AR or R is held by its master (AXI rule) and is not accepted until IDLE.
  - Upstream arvalid/araddr changes after acceptance have no effect.
- Backpressure: if m[g]_rready is low while s_rvalid is high, remain in R and keep s_rready=0.
- Fairness: with continuous requests from both, grants strictly alternate, starting with m0.
- Ignored inputs: s_rvalid outside R; s_arready outside AR.
- Reset mid-operation: return to IDLE next edge, drop s_arvalid and s_rready, keep no pending state. The memory shares areset.

Test Plan:
- Single read: m0 read at 0x10, mem returns 0xDEADBEEF with rresp=0.
  - m0_arready is high in cycle 0; s_arvalid is high from cycle 1 with s_araddr=0x10.
  - m0_rvalid carries 0xDEADBEEF; m1_rvalid stays 0 throughout.
- Simultaneous requests: m0 at 0x4 and m1 at 0x8 in the same IDLE cycle, out of reset.
  - m0 is served first; m1_arready rises only in the IDLE cycle after m0's R handshake.
  - The next grant order is m1, then m0.
- Continuous requests: both requesters hold arvalid for 4 transactions.
  - rd_grant sequence is 0,1,0,1; no requester is ever accepted twice in a row.
- Backpressure: m1 read while m1_rready is held low 5 cycles after s_rvalid.
  - s_rready=0 for those 5 cycles; state stays R.
  - Completes the cycle m1_rready rises; rdata/rresp are passed unchanged (incl. rresp=2'b10).
- Busy master: m0 raises arvalid while m1's transaction is in AR.
  - m0_arready stays 0 until the FSM returns to IDLE; s_araddr is unchanged during m1's transaction.
- Reset mid-read: assert areset for 1 cycle while in R.
  - Next cycle: busy=0, s_arvalid=0, s_rready=0, rd_grant=1.
  - A subsequent m1-only request is granted normally.
